hazard_sequencer: RTL

- Pipeline hazard controller for the 5-stage MIPS core.
- Drives `ctrl` into the ID/EX register (1 = pass decoded controls, 0 = inject bubble), plus PC and IF/ID write/flush enables.
- Sequences three things: the post-reset pipeline-fill bubbles (the ID/EX register has no reset), single-cycle load-use stalls, and multi-cycle taken-branch flushes.

---
 rtl/hazard_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//
// Pipeline hazard controller for the 5-stage MIPS core. It decides, every
// cycle, whether the ID/EX register takes the decoded controls or a bubble,
// and drives the PC and IF/ID write/flush enables. Three things are sequenced:
//   - pipeline-fill bubbles after reset (ID/EX has no reset of its own),
//   - single-cycle load-use stalls,
//   - multi-cycle flushes after a taken branch/jump.
//
// Parameters:
//   INIT_BUBBLES   bubble cycles forced after reset release (1..15)
//   BRANCH_PENALTY flush cycles per taken branch incl. resolving cycle (1..8)
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-low reset
//   ID_EX_memread  instruction in EX is a load
//   ID_EX_rt       destination register of the instruction in EX
//   IF_ID_rs       rs field of the instruction in ID
//   IF_ID_rt       rt field of the instruction in ID
//   IF_ID_uses_rt  instruction in ID reads rt as a source
//   branch_taken   taken branch/jump resolved this cycle
//   pc_write       PC load enable
//   IF_ID_write    IF/ID write enable (0 = hold)
//   IF_ID_flush    IF/ID clears to NOP on the next edge
//   ctrl           ID/EX control pass (1) or bubble (0)
//   hz_state       0 INIT, 1 RUN, 2 FLUSH (0 while in reset)
//
// Optional build macro HAZARD_SEQ_STATS_EN adds:
//   stats_clr      clears bubble_cnt on the next edge (wins over increment)
//   bubble_cnt     saturating count of bubble cycles outside reset
// -----------------------------------------------------------------------------
module hazard_sequencer #(
  parameter int INIT_BUBBLES   = 3,
  parameter int BRANCH_PENALTY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ID_EX_memread,
  input  logic [4:0] ID_EX_rt,
  input  logic [4:0] IF_ID_rs,
  input  logic [4:0] IF_ID_rt,
  input  logic       IF_ID_uses_rt,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       ctrl,
`ifdef HAZARD_SEQ_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] bubble_cnt,
`endif
  output logic [1:0] hz_state
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  localparam logic [3:0] INIT_CNT = 4'(INIT_BUBBLES - 1);
  // The resolving cycle is the first flush cycle, so FLUSH covers the rest.
  localparam logic [3:0] BR_CNT   = 4'((BRANCH_PENALTY > 1) ? (BRANCH_PENALTY - 2) : 0);
  localparam logic       BR_MULTI = (BRANCH_PENALTY > 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu;

  // Register 0 never creates a dependency, so a load to $zero never stalls.
  assign lu = ID_EX_memread && (ID_EX_rt != 5'd0) &&
              ((ID_EX_rt == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b0;
    IF_ID_write = 1'b0;
    IF_ID_flush = 1'b1;
    ctrl        = 1'b0;
    if (rst) begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == 4'd0) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
        ST_RUN: begin
          if (branch_taken) begin
            // Branch wins over a simultaneous load-use: the load's consumer
            // is on the wrong path and gets squashed anyway.
            pc_write    = 1'b1;
            IF_ID_write = 1'b1;
            IF_ID_flush = 1'b1;
            if (BR_MULTI) begin
              state_d = ST_FLUSH;
              cnt_d   = BR_CNT;
            end
          end else if (lu) begin
            IF_ID_flush = 1'b0;
          end else begin
            pc_write    = 1'b1;
            IF_ID_write = 1'b1;
            IF_ID_flush = 1'b0;
            ctrl        = 1'b1;
          end
        end
        ST_FLUSH: begin
          pc_write    = 1'b1;
          IF_ID_write = 1'b1;
          if (cnt_q == 4'd0) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
        default: begin
          // Unused code 3: act as an expiring INIT so we land in RUN next.
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_INIT;
      cnt_q   <= INIT_CNT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz_state = rst ? state_q : ST_INIT;

`ifdef HAZARD_SEQ_STATS_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (stats_clr)
      bubble_cnt_d = 16'd0;
    else if (!ctrl && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) bubble_cnt_q <= 16'd0;
    else      bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
